seq_scan_arbiter: RTL and testbench
===================================

// Module: seq_scan_arbiter
// PURPOSE
//  Shares one serial Moore pattern detector among NREQ requesters. Grants one
//  requester at a time round-robin, latches its W-bit word, feeds it MSB-first
//  through the detector (one bit/clk) and returns the match count. Sits in front
//  of the sequence-detector datapath so multiple clients avoid per-client FSMs.
// PARAMETERS
//  NREQ    2        number of requesters (2..8)
//  W       8        word width scanned per grant (>= PLEN)
//  PLEN    4        pattern length in bits (2..8)
//  PATTERN 4'b1101  pattern, MSB = first bit received
// PORTS
//  clk        in   1               clock, rising edge
//  reset      in   1               async, active-low reset
//  req        in   NREQ            level request per requester
//  data_in    in   NREQ*W          word i at [i*W +: W]
//  overlap    in   1               1 = overlapping detection, 0 = non-overlapping
//  gnt        out  NREQ            one-hot grant, held for whole scan
//  busy       out  1               scan in progress (SHIFT or DONE)
//  done       out  1               1-cycle pulse, result valid
//  match_cnt  out  $clog2(W+1)     matches found in granted word
//  match_id   out  $clog2(NREQ)    index of requester the result belongs to
// BEHAVIOUR
//  - Reset (reset==0): state IDLE, gnt=0, busy=0, done=0, match_cnt=0,
//    match_id=0, detector in S0, RR pointer -> requester 0 highest priority.
//  - FSM IDLE -> SHIFT -> DONE -> IDLE.
//  - IDLE: if |req, winner = first set req at/after RR pointer (wrap at NREQ);
//    latch word and overlap, gnt<=onehot(winner), match_id<=winner,
//    match_cnt<=0, bit idx<=W-1, detector<=S0, pointer<=winner+1 mod NREQ.
//  - SHIFT: one bit/clk, word[idx]; detector is a PLEN+1 state Moore FSM
//    (S0..S_PLEN, S_PLEN = match). match_cnt increments on the edge the
//    detector enters S_PLEN. Exit after idx==0 is consumed (exactly W cycles).
//  - Leaving S_PLEN: overlap=1 -> as state (longest proper prefix==suffix of
//    PATTERN), non-overlap=0 -> as if from S0 (matched bits not reused).
//    Mismatch transitions use the same prefix/suffix fallback (computed at
//    elaboration, no runtime table).
//  - DONE: done=1 for exactly 1 cycle; match_cnt/match_id stable from DONE
//    until next grant. gnt stays high through DONE, drops on entry to IDLE.
//  - Latency: gnt rises cycle 0; done high in cycle W+1. Min 1 IDLE cycle
//    between grants -> next gnt rises 2 cycles after done.
//  - req/data_in changes after grant are ignored; withdrawing req mid-scan
//    does not abort, result is still delivered with done.
//  - match_cnt cannot overflow (max W/1 fits $clog2(W+1)).
//  - reset asserted mid-scan: immediate return to reset values, no done.
// CONFIGURATION
//  SEQ_SCAN_FIRSTPOS_EN defined: extra port first_pos out $clog2(W)+1 bits =
//   bit index (0 = MSB) of last bit of the first match in the word; all-ones
//   if no match; reset 0, valid with done, cleared on grant.
//  Not defined: port absent, no position logic synthesised.
// TESTING  (NREQ=2, W=8, PATTERN=1101)
//  1 req=01, word0=8'hDA, overlap=0 -> gnt=01, done at cycle 9, cnt=1, id=0
//  2 req=01, word0=8'hDA, overlap=1 -> cnt=2 (1101 at bits 0-3 and 3-6)
//  3 req=11 held from reset, words 8'hDB/8'h00 -> grants 01,10,01,10...;
//    id alternates 0/1; cnt 1 then 0 (overlap=0)
//  4 req=10, word1=8'h00 -> cnt=0, done exactly 1 cycle, gnt drops next clk
//  5 reset low during SHIFT cycle 4 -> gnt=0, busy=0, no done; after release
//    req=11 grants requester 0 first
//  6 FIRSTPOS_EN, word=8'hDA -> first_pos=3; word=8'h00 -> first_pos all-ones

Source files
------------

// File: rtl/seq_scan_arbiter.sv
// seq_scan_arbiter
//   Round-robin front end for one shared serial Moore pattern detector.
//   A granted requester's W-bit word is latched and scanned MSB-first,
//   one bit per clock, and the number of PATTERN matches is returned with
//   a one-cycle done pulse. The detector's next-state table is derived
//   from PATTERN at elaboration using the prefix/suffix fallback.
//   Optional feature macro: SEQ_SCAN_FIRSTPOS_EN adds the first_pos port,
//   which reports the position of the last bit of the first match.
//   Handshake: req is a level; a grant is taken only in IDLE and then holds
//   for the full scan regardless of req/data_in; done marks result valid.
module seq_scan_arbiter #(
    parameter int              NREQ    = 2,
    parameter int              W       = 8,
    parameter int              PLEN    = 4,
    parameter logic [PLEN-1:0] PATTERN = 4'b1101
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*W-1:0]         data_in,
    input  logic                      overlap,
    output logic [NREQ-1:0]           gnt,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(W+1)-1:0]    match_cnt,
    output logic [$clog2(NREQ)-1:0]   match_id
`ifdef SEQ_SCAN_FIRSTPOS_EN
    ,
    output logic [$clog2(W):0]        first_pos
`endif
);

    localparam int RW = $clog2(NREQ);
    localparam int XW = $clog2(W);
    localparam int SW = $clog2(PLEN+1);
    localparam int NS = 1 << SW;
    localparam logic [SW-1:0] S_MATCH = SW'(PLEN);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    // Detector state reached from "s bits matched" after receiving bit b.
    function automatic int delta(input int s, input int b);
        int  res;
        int  p;
        bit  ok;
        bit  sv;
        res = 0;
        for (int k = s + 1; k >= 1; k--) begin
            if (res == 0) begin
                ok = 1'b1;
                for (int i = 0; i < k; i++) begin
                    p  = s + 1 - k + i;
                    sv = (p < s) ? PATTERN[PLEN-1-p] : (b != 0);
                    if (PATTERN[PLEN-1-i] != sv) ok = 1'b0;
                end
                if (ok) res = k;
            end
        end
        return res;
    endfunction

    // Longest proper prefix of PATTERN that is also a suffix.
    function automatic int border();
        int  res;
        bit  ok;
        res = 0;
        for (int k = PLEN - 1; k >= 1; k--) begin
            if (res == 0) begin
                ok = 1'b1;
                for (int i = 0; i < k; i++) begin
                    if (PATTERN[PLEN-1-i] != PATTERN[PLEN-1-(PLEN-k+i)]) ok = 1'b0;
                end
                if (ok) res = k;
            end
        end
        return res;
    endfunction

    localparam int BORDER = border();

    state_t          state, state_nxt;
    logic [RW-1:0]   ptr;
    logic [W-1:0]    word;
    logic            ovl;
    logic [XW-1:0]   idx;
    logic [SW-1:0]   det, det_eff, det_nxt;
    logic            win_found;
    logic [RW-1:0]   win_idx;
    logic [SW-1:0]   tab [NS][2];

    // Constant transition table; entries beyond PLEN-1 are unreachable.
    for (genvar s = 0; s < NS; s++) begin : g_state
        for (genvar b = 0; b < 2; b++) begin : g_bit
            localparam int NX = (s < PLEN) ? delta(s, b) : 0;
            assign tab[s][b] = SW'(NX);
        end
    end

    // Round-robin pick: first set request at or after the pointer.
    always_comb begin
        int j;
        j         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(ptr) + i) % NREQ;
            if (!win_found && req[j]) begin
                win_found = 1'b1;
                win_idx   = RW'(j);
            end
        end
    end

    // Detector step; a completed match restarts from the border or S0.
    always_comb begin
        det_eff = det;
        if (det == S_MATCH) det_eff = ovl ? SW'(BORDER) : '0;
        det_nxt = tab[det_eff][word[idx]];
    end

    // Control FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Control FSM next state and status outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE:  if (win_found) state_nxt = S_SHIFT;
            S_SHIFT: begin
                busy = 1'b1;
                if (idx == '0) state_nxt = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Grant capture, bit shifting and match counting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr       <= '0;
            word      <= '0;
            ovl       <= 1'b0;
            idx       <= '0;
            det       <= '0;
            gnt       <= '0;
            match_cnt <= '0;
            match_id  <= '0;
        end else begin
            case (state)
                S_IDLE: if (win_found) begin
                    word      <= data_in[win_idx*W +: W];
                    ovl       <= overlap;
                    gnt       <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
                    match_id  <= win_idx;
                    match_cnt <= '0;
                    idx       <= XW'(W-1);
                    det       <= '0;
                    ptr       <= (win_idx == RW'(NREQ-1)) ? '0 : win_idx + 1'b1;
                end
                S_SHIFT: begin
                    det <= det_nxt;
                    idx <= idx - 1'b1;
                    if (det_nxt == S_MATCH) match_cnt <= match_cnt + 1'b1;
                end
                S_DONE:  gnt <= '0;
                default: gnt <= '0;
            endcase
        end
    end

`ifdef SEQ_SCAN_FIRSTPOS_EN
    // First-match position; all-ones stands for "no match yet".
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            first_pos <= '0;
        end else if (state == S_IDLE && win_found) begin
            first_pos <= '1;
        end else if (state == S_SHIFT && det_nxt == S_MATCH && first_pos == '1) begin
            first_pos <= ($clog2(W)+1)'(W-1) - ($clog2(W)+1)'(idx);
        end
    end
`endif

endmodule

// File: tb/tb_seq_scan_arbiter.sv
// tb_seq_scan_arbiter
//   Directed bench for seq_scan_arbiter with NREQ=2, W=8, PATTERN=1101.
//   Expected match counts are hand-computed and queued per scan.
module tb_seq_scan_arbiter;

    localparam int NREQ = 2;
    localparam int W    = 8;

    logic            clk;
    logic            reset;
    logic [NREQ-1:0] req;
    logic [NREQ*W-1:0] data_in;
    logic            overlap;
    logic [NREQ-1:0] gnt;
    logic            busy;
    logic            done;
    logic [3:0]      match_cnt;
    logic [0:0]      match_id;
`ifdef SEQ_SCAN_FIRSTPOS_EN
    logic [3:0]      first_pos;
`endif

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    seq_scan_arbiter #(.NREQ(NREQ), .W(W), .PLEN(4), .PATTERN(4'b1101)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .data_in   (data_in),
        .overlap   (overlap),
        .gnt       (gnt),
        .busy      (busy),
        .done      (done),
        .match_cnt (match_cnt),
        .match_id  (match_id)
`ifdef SEQ_SCAN_FIRSTPOS_EN
        ,
        .first_pos (first_pos)
`endif
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Wait for done on falling edges; returns cycles waited (40 = timeout).
    task automatic wait_done(output int n);
        bit seen;
        n    = 0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            n++;
            if (done) seen = 1'b1;
        end
    endtask

    // One full grant: request, check grant, scramble inputs, check result.
    task automatic run_scan(input string tag, input logic [1:0] r, input logic [7:0] w0,
                            input logic [7:0] w1, input logic ovl, input logic [1:0] egnt,
                            input int eid, input logic [3:0] ecnt);
        int n;
        logic [3:0] e;
        @(negedge clk);
        req     = r;
        data_in = {w1, w0};
        overlap = ovl;
        exp_q.push_back(ecnt);
        @(negedge clk);
        check({tag, "_gnt"}, 32'(gnt), 32'(egnt));
        check({tag, "_busy"}, 32'(busy), 32'd1);
        req     = '0;
        data_in = ~data_in;
        overlap = ~ovl;
        wait_done(n);
        e = exp_q.pop_front();
        check({tag, "_latency"}, 32'(n), 32'(W));
        check({tag, "_cnt"}, 32'(match_cnt), 32'(e));
        check({tag, "_id"}, 32'(match_id), 32'(eid));
        check({tag, "_gnt_in_done"}, 32'(gnt), 32'(egnt));
`ifdef SEQ_SCAN_FIRSTPOS_EN
        if (w0 == 8'hDA && r == 2'b01) check({tag, "_fpos"}, 32'(first_pos), 32'd3);
        if (w0 == 8'h00 && r == 2'b01) check({tag, "_fpos"}, 32'(first_pos), 32'hF);
`endif
        @(negedge clk);
        check({tag, "_done_1cyc"}, 32'(done), 32'd0);
        check({tag, "_gnt_drop"}, 32'(gnt), 32'd0);
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
        check({tag, "_cnt_hold"}, 32'(match_cnt), 32'(e));
    endtask

    initial begin
        int n;
        logic [1:0] eg;
        reset   = 1'b0;
        req     = '0;
        data_in = '0;
        overlap = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cnt", 32'(match_cnt), 32'd0);
        check("rst_id", 32'(match_id), 32'd0);
        reset = 1'b1;

        // 0xDA = 1101_1010: one match non-overlapping, two overlapping.
        run_scan("t1", 2'b01, 8'hDA, 8'h00, 1'b0, 2'b01, 0, 4'd1);
        run_scan("t2", 2'b01, 8'hDA, 8'h00, 1'b1, 2'b01, 0, 4'd2);
        run_scan("t4", 2'b10, 8'hFF, 8'h00, 1'b0, 2'b10, 1, 4'd0);
        run_scan("t7", 2'b10, 8'h00, 8'hDB, 1'b1, 2'b10, 1, 4'd2);

        // Both requesters held from reset: alternating grants, 2-cycle gap.
        @(negedge clk);
        reset   = 1'b0;
        req     = 2'b11;
        data_in = {8'h00, 8'hDB};
        overlap = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            eg = (g % 2 == 1) ? 2'b10 : 2'b01;
            check($sformatf("t3_gnt%0d", g), 32'(gnt), 32'(eg));
            wait_done(n);
            check($sformatf("t3_lat%0d", g), 32'(n), 32'(W));
            check($sformatf("t3_cnt%0d", g), 32'(match_cnt), (g % 2 == 1) ? 32'd0 : 32'd1);
            check($sformatf("t3_id%0d", g), 32'(match_id), 32'(g % 2));
            if (g == 3) req = '0;
            @(negedge clk);
            check($sformatf("t3_idle%0d", g), 32'(gnt), 32'd0);
            @(negedge clk);
        end

        // Reset in the fourth shift cycle aborts with no done.
        req     = 2'b01;
        data_in = {8'h00, 8'hDA};
        @(negedge clk);
        check("t5_gnt", 32'(gnt), 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("t5_rst_gnt", 32'(gnt), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_done", 32'(done), 32'd0);
        check("t5_rst_cnt", 32'(match_cnt), 32'd0);
        req = 2'b11;
        repeat (2) @(negedge clk);
        check("t5_no_done", 32'(done), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("t5_first_gnt", 32'(gnt), 32'd1);
        req = '0;
        wait_done(n);
        check("t5_lat", 32'(n), 32'(W));
        check("t5_cnt", 32'(match_cnt), 32'd1);
        @(negedge clk);

`ifdef SEQ_SCAN_FIRSTPOS_EN
        run_scan("t6a", 2'b01, 8'hDA, 8'h00, 1'b0, 2'b01, 0, 4'd1);
        run_scan("t6b", 2'b01, 8'h00, 8'h00, 1'b0, 2'b01, 0, 4'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
